// File: rtl/imem_loader_ctrl.sv
// Parametrised instruction memory: streamed boot load, handshaked registered fetch.
// Optional feature: define IMEM_PARITY_EN to store and check one even-parity bit per word.
module imem_loader_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              Clk,
    input  logic              Rstn,
    input  logic              LdStart,
    input  logic [ADDR_W-1:0] LdBase,
    input  logic              LdValid,
    output logic              LdReady,
    input  logic [DATA_W-1:0] LdData,
    input  logic              LdLast,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchGnt,
    output logic [DATA_W-1:0] Instruction,
    output logic              InsValid,
    input  logic              InsStall,
    output logic              AddrErr,
    output logic              LdOvf,
    output logic              Loading,
    output logic              ParErr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ld_ptr;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              ld_accept;
    logic              ld_write;
    logic              fetch_in_range;
    logic              par_bad;

    // A restart in LOAD discards the word offered in the same cycle.
    assign ld_accept      = LdReady && LdValid && !LdStart;
    assign ld_write       = ld_accept && Rstn && ({1'b0, ld_ptr} < DEPTH_L);
    assign fetch_in_range = {1'b0, FetchAddr} < DEPTH_L;
    assign FetchGnt       = (state == RUN) && FetchReq && !(InsValid && InsStall) && !LdStart;
    assign rd_word        = mem[FetchAddr[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
    assign wr_word = {^LdData, LdData};
    assign par_bad = ^rd_word;
`else
    assign wr_word = LdData;
    assign par_bad = 1'b0;
`endif

    // NOTE: the array has no reset on purpose: a program must survive a reset and RAM macros have no reset port.
    always_ff @(posedge Clk) begin
        if (ld_write) begin
            mem[ld_ptr[IDX_W-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            state       <= IDLE;
            LdReady     <= 1'b0;
            Loading     <= 1'b0;
            ld_ptr      <= '0;
            LdOvf       <= 1'b0;
            InsValid    <= 1'b0;
            Instruction <= '0;
            AddrErr     <= 1'b0;
            ParErr      <= 1'b0;
        end else begin
            // Fetch response: load on grant, hold under stall, otherwise drain.
            if (FetchGnt) begin
                InsValid    <= 1'b1;
                AddrErr     <= !fetch_in_range;
                Instruction <= fetch_in_range ? rd_word[DATA_W-1:0] : '0;
                ParErr      <= fetch_in_range && par_bad;
            end else if (!(InsValid && InsStall) || LdStart) begin
                InsValid <= 1'b0;
                AddrErr  <= 1'b0;
                ParErr   <= 1'b0;
            end

            if (LdStart) begin
                state   <= LOAD;
                LdReady <= 1'b1;
                Loading <= 1'b1;
                ld_ptr  <= LdBase;
                LdOvf   <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (ld_accept) begin
                            if (ld_ptr >= LAST_ADDR) begin
                                ld_ptr <= '0;
                                LdOvf  <= 1'b1;
                            end else begin
                                ld_ptr <= ld_ptr + 1'b1;
                            end
                            if (LdLast) begin
                                state   <= RUN;
                                LdReady <= 1'b0;
                                Loading <= 1'b0;
                            end
                        end
                    end
                    IDLE, RUN: begin
                        LdReady <= 1'b0;
                        Loading <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        LdReady <= 1'b0;
                        Loading <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Parametrised instruction memory with a boot-load streaming port and a handshaked, registered fetch port. Successor to the fixed 4K x 32 instruction RAM: depth and word width are generic, the program is loaded from a stream instead of being written word-by-word by the top level, and fetch responses carry valid/stall qualification for a stalling pipeline. Sits between the boot loader/debug link and the IF stage of the RISC core.

## Interface
- DATA_W, 32, instruction word width in bits
- ADDR_W, 12, word-address width
- DEPTH, 4096, number of words; DEPTH <= 2**ADDR_W
- Clk  in  1  single clock; all logic rising-edge
- Rstn  in  1  synchronous, active-low reset
- LdStart  in  1  pulse: begin program load at LdBase
- LdBase  in  ADDR_W  first load address, sampled with LdStart
- LdValid  in  1  load word present
- LdReady  out  1  load word accepted when LdValid && LdReady
- LdData  in  DATA_W  load word
- LdLast  in  1  marks final word of program
- FetchReq  in  1  fetch request
- FetchAddr  in  ADDR_W  word address of fetch
- FetchGnt  out  1  request accepted this cycle
- Instruction  out  DATA_W  fetched word
- InsValid  out  1  Instruction valid
- InsStall  in  1  consumer cannot take Instruction; hold it
- AddrErr  out  1  fetched address >= DEPTH, aligned with InsValid
- LdOvf  out  1  sticky: load address wrapped
- Loading  out  1  high in LOAD state
- ParErr  out  1  parity mismatch on fetched word (see Configuration)

## Operation
- States: IDLE (reset, no program), LOAD, RUN.
- IDLE: LdStart -> LOAD. FetchGnt=0, LdReady=0.
- LOAD: LdReady=1. Each accepted word written at load pointer (starts at LdBase), pointer +1; pointer at DEPTH-1 wraps to 0 and sets LdOvf. Accepted word with LdLast -> RUN next cycle. LdStart in LOAD restarts at new LdBase; the same-cycle word is discarded.
- RUN: FetchGnt = !(InsValid && InsStall) && !LdStart. LdStart -> LOAD; InsValid cleared next cycle; LdOvf cleared.
- Out-of-range fetch (FetchAddr >= DEPTH): granted, Instruction=0 (NOP), AddrErr=1 with InsValid; memory not read.
- Memory contents not cleared by reset; survive reset mid-load (partially written).

## Timing
- Reset values: LdReady=0, FetchGnt=0, Instruction=0, InsValid=0, AddrErr=0, LdOvf=0, Loading=0, ParErr=0; state IDLE.
- Fetch latency 1: grant at cycle N -> Instruction/InsValid at N+1. Back-to-back grants give one word per cycle.
- Stall: InsValid && InsStall holds Instruction, AddrErr, ParErr, InsValid unchanged; no grant.
- InsValid falls the cycle after a cycle with InsValid && !InsStall && !FetchGnt.
- Load write takes effect at end of accept cycle; a fetch to that address granted the next cycle returns the new word.
- LdStart beats FetchReq in the same cycle; the fetch is not granted.

## Configuration
- IMEM_PARITY_EN defined: each word stores one extra even-parity bit computed on write; on fetch, ParErr=1 with InsValid when recomputed parity differs. Memory is DATA_W+1 wide.
- Undefined: no parity storage; ParErr tied 0.

## Test plan
- Reset then LdStart, LdBase=0, stream 0x00000013, 0x00100093, 0x00200113 (last) -> Loading 1 for 3 accept cycles, then RUN; fetch 0,1,2 back-to-back -> same words on cycles N+1..N+3, InsValid continuous.
- InsStall=1 for 3 cycles while InsValid -> Instruction frozen, FetchGnt=0; release -> next word 1 cycle after grant.
- DEPTH=16, LdBase=14, stream 4 words -> written at 14,15,0,1, LdOvf=1.
- FetchAddr=DEPTH in RUN -> Instruction=0, AddrErr=1, InsValid=1 one cycle later.
- Rstn low mid-load, then fetch attempt -> IDLE, FetchGnt=0; reload without clearing preserves untouched words.
- IMEM_PARITY_EN: backdoor-flip one stored data bit at addr 5, fetch 5 -> ParErr=1 with InsValid; without macro ParErr=0.
